division: RTL and testbench
===========================

DIVISION -- requirements
Module: division

Interface
REQ-001 Parameter W, default 8, operand width in bits; out width is 2*W with W fraction bits (Q(W).(W) format).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request pulse; sampled only while busy=0.
REQ-005 a  input  W  unsigned dividend (numerator).
REQ-006 b  input  W  unsigned divisor (denominator).
REQ-007 out  output  2W  unsigned quotient floor((a << W) / b), registered.
REQ-008 valid  output  1  one-cycle pulse, out holds a new result.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 The design SHALL use one clock (clk); reset (rst) SHALL be asynchronous and active-high.

Function
REQ-011 The quotient SHALL be the fixed-point ratio a/b with W fraction bits, truncated toward zero: out = floor(a*2^W / b).
REQ-012 Implementation SHALL be a sequential restoring divider: 2W-bit dividend {a, W zeros}, W-bit divisor, one quotient bit per cycle, MSB first, with a W+1-bit partial remainder.
REQ-013 States SHALL be IDLE and RUN; IDLE->RUN on the clk edge sampling start=1, RUN->IDLE after the 2W-th iteration.
REQ-014 On the accepting edge (E0), a and b SHALL be latched internally, busy SHALL go high and the iteration counter SHALL clear; later changes on a/b SHALL NOT affect the running operation.
REQ-015 Edges E1..E2W SHALL each perform one iteration; at edge E2W out SHALL load the quotient, valid SHALL rise and busy SHALL fall.
REQ-016 valid SHALL be high for exactly one cycle (cleared on edge E2W+1); latency from the accepting edge to the valid edge SHALL be 2W cycles (16 for W=8).
REQ-017 out SHALL hold its last value until the next result is loaded.
REQ-018 start while busy=1 SHALL be ignored with no queuing.
REQ-019 start=1 in the same cycle valid is high SHALL be accepted, since busy is already 0.
REQ-020 b=0 SHALL yield out = all ones (0xFFFF for W=8) with the same latency and valid pulse; no other flag.
REQ-021 a=0 with b!=0 SHALL yield out=0.
REQ-022 The maximum result, a=2^W-1 and b=1, SHALL equal (2^W-1)<<W (0xFF00) without overflow.
REQ-023 out SHALL be exact for all a, b with b!=0, including a>b (ratios >= 1.0).

Reset
REQ-024 While rst=1, state SHALL be IDLE, and out=0, valid=0, busy=0, counter and remainder cleared, independent of clk.
REQ-025 rst asserted mid-operation SHALL abort it immediately; no valid pulse SHALL follow, and the block SHALL accept start on the first edge after rst deasserts.

Verification
REQ-026 a=100, b=200, start pulse -> after 16 cycles valid=1, out=0x0080 (0.5).
REQ-027 a=14, b=160 -> out=0x0016 (22, truncated 22.4).
REQ-028 a=255, b=1 -> out=0xFF00; a=0, b=7 -> out=0x0000; a=200, b=100 -> out=0x0200.
REQ-029 a=50, b=0 -> out=0xFFFF after 16 cycles, valid pulses once.
REQ-030 Start a=100, b=200; change a/b and pulse start at cycle 5 -> single valid at cycle 16, out=0x0080; busy high over cycles 1-16.
REQ-031 Start, then rst at cycle 8 -> out=0, busy=0, no valid; a new start a=14, b=160 then completes with out=0x0016.

Source files
------------

// File: rtl/division.sv
// Sequential restoring divider: out = floor((a << W) / b), Q(W).(W) result.
// One quotient bit per cycle, MSB first; b = 0 yields all ones.
module division #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] out,
  output logic           valid,
  output logic           busy
);

  localparam int CW = $clog2(2 * W);
  localparam logic [CW-1:0] LAST = CW'(2 * W - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W:0]      r_rem;
  logic [2*W-1:0]  r_dvd;
  logic [2*W-1:0]  r_quo;
  logic [W-1:0]    r_b;
  logic [2*W-1:0]  r_out;
  logic            r_valid;
  logic            r_busy;

  logic [W:0]      w_sh;
  logic            w_ge;
  logic [W:0]      w_rem_nxt;
  logic [2*W-1:0]  w_quo_nxt;

  // A set top remainder bit only arises with b = 0, where every bit is 1.
  assign w_sh      = {r_rem[W-1:0], r_dvd[2*W-1]};
  assign w_ge      = r_rem[W] | (w_sh >= {1'b0, r_b});
  assign w_rem_nxt = w_ge ? (w_sh - {1'b0, r_b}) : w_sh;
  assign w_quo_nxt = {r_quo[2*W-2:0], w_ge};

  assign out   = r_out;
  assign valid = r_valid;
  assign busy  = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_quo   <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_b     <= b;
            r_dvd   <= {a, {W{1'b0}}};
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_rem <= w_rem_nxt;
          r_dvd <= r_dvd << 1;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_out   <= w_quo_nxt;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_division.sv
// Directed bench for division: vector table plus overlap, reset-abort
// and back-to-back sequences.
module tb_division;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2*W-1:0] out;
  logic           valid;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  division #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .out   (out),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] q;
  } vec_t;

  vec_t vt [11];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called #1 after the accepting edge; returns #1 after the valid edge.
  task automatic wait_result(input string name, input logic [2*W-1:0] q);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        n = i;
        break;
      end
    end
    check({name, " latency"}, n, 2 * W);
    check({name, " out"}, out, q);
    check({name, " busy low"}, busy, 0);
  endtask

  task automatic do_div(input string name, input logic [W-1:0] ta,
                        input logic [W-1:0] tb, input logic [2*W-1:0] q);
    @(negedge clk);
    a = ta;
    b = tb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, " busy"}, busy, 1);
    wait_result(name, q);
    @(posedge clk);
    #1;
    check({name, " valid one"}, valid, 0);
    check({name, " hold"}, out, q);
  endtask

  initial begin
    int pulses;

    vt[0]  = '{8'd100, 8'd200, 16'h0080};
    vt[1]  = '{8'd14,  8'd160, 16'h0016};
    vt[2]  = '{8'd255, 8'd1,   16'hFF00};
    vt[3]  = '{8'd0,   8'd7,   16'h0000};
    vt[4]  = '{8'd200, 8'd100, 16'h0200};
    vt[5]  = '{8'd50,  8'd0,   16'hFFFF};
    vt[6]  = '{8'd1,   8'd255, 16'h0001};
    vt[7]  = '{8'd255, 8'd255, 16'h0100};
    vt[8]  = '{8'd3,   8'd2,   16'h0180};
    vt[9]  = '{8'd7,   8'd3,   16'h0255};
    vt[10] = '{8'd1,   8'd3,   16'h0055};

    #2;
    check("reset out", out, 0);
    check("reset valid", valid, 0);
    check("reset busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      do_div($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].q);

    // Operands and start changed mid-run must not disturb the result.
    @(negedge clk);
    a = 8'd100;
    b = 8'd200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
      if (k < 16) check($sformatf("ovl busy c%0d", k), busy, 1);
      if (k == 16) begin
        check("ovl valid c16", valid, 1);
        check("ovl out", out, 16'h0080);
        check("ovl busy c16", busy, 0);
      end
      if (k == 5) begin
        a = 8'd7;
        b = 8'd3;
        start = 1'b1;
      end
      if (k == 6) start = 1'b0;
    end
    check("ovl pulses", pulses, 1);

    // Start accepted in the valid cycle.
    do_div("b2b first", 8'd200, 8'd100, 16'h0200);
    @(negedge clk);
    a = 8'd255;
    b = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b idle out", out, 16'h0200);
    a = 8'd14;
    b = 8'd160;
    start = 1'b1;
    wait_result("b2b A", 16'hFF00);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b accept busy", busy, 1);
    check("b2b accept valid", valid, 0);
    wait_result("b2b B", 16'h0016);

    // Reset aborts a run; restart on the first edge after release.
    @(negedge clk);
    a = 8'd100;
    b = 8'd200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort out", out, 0);
    check("abort busy", busy, 0);
    check("abort valid", valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
    end
    check("abort no valid", pulses, 0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    a = 8'd14;
    b = 8'd160;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("restart busy", busy, 1);
    wait_result("restart", 16'h0016);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
